// File: rtl/dac8411_write.sv
// dac8411_write: streams data_in to a DAC8411 as repeated 24-bit SYNC/SCLK/DIN frames, SCLK = clk/2.
module dac8411_write #(
  parameter int         DAC_WIDTH        = 16,
  parameter logic [1:0] PD_MODE          = 2'b00,
  parameter int         SYNC_HIGH_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [DAC_WIDTH-1:0] data_in,
  output logic                 sclk,
  output logic                 serial_data_out,
  output logic                 syncn
);
  localparam logic [0:0] GAP   = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int         CW    = $clog2(SYNC_HIGH_CYCLES);
  localparam int         LSH   = 16 - DAC_WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_HIGH_CYCLES - 1);
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   sr_q, sr_d;
  logic          sync_q, sync_d, sclk_q, sclk_d, sdo_q, sdo_d;
  logic [15:0]   data16;
  logic [23:0]   word;
  assign data16 = 16'(data_in) << LSH;
  assign word   = {PD_MODE, data16, 6'b000000};
  // sclk_q doubles as the phase bit: high means the next edge is an sclk falling edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    if (state_q == GAP) begin
      if (cnt_q == CNT_LAST) begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = 5'd23;
        sr_d    = word;
        sync_d  = 1'b0;
        sclk_d  = 1'b1;
        sdo_d   = word[23];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (sclk_q) begin
      sclk_d = 1'b0;
    end else if (bit_q == 5'd0) begin
      state_d = GAP;
      sync_d  = 1'b1;
      sdo_d   = 1'b0;
    end else begin
      bit_d  = bit_q - 1'b1;
      sclk_d = 1'b1;
      sr_d   = {sr_q[22:0], 1'b0};
      sdo_d  = sr_q[22];
    end
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= GAP;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
    end
  end
  assign syncn           = sync_q;
  assign sclk            = sclk_q;
  assign serial_data_out = sdo_q;
endmodule

// File: tb/tb_dac8411_write.sv
// tb_dac8411_write: directed stimulus with a frame scoreboard checked on each syncn rise.
module tb_dac8411_write;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] data_in = 16'hAAAA;
  logic        sclk, serial_data_out, syncn;
  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_q[$];
  int          frames = 0;
  int          nfall = 0;
  int          gap = 0;
  bit          gap_valid = 0;
  logic [23:0] bits = '0;
  logic        prev_sclk = 1'b0, prev_sdo = 1'b0, prev_sync = 1'b1;
  dac8411_write dut (
    .clk(clk), .aresetn(aresetn), .data_in(data_in),
    .sclk(sclk), .serial_data_out(serial_data_out), .syncn(syncn)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] frame_of(input logic [15:0] d);
    return {2'b00, d, 6'b000000};
  endfunction
  // monitor: samples on clk negedge, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!aresetn) begin
      prev_sclk = 1'b0; prev_sdo = 1'b0; prev_sync = 1'b1;
      nfall = 0; gap = 0; gap_valid = 0; bits = '0;
    end else begin
      if (prev_sclk && !sclk) begin
        tests++;
        assert (serial_data_out === prev_sdo) else begin
          fails++; $error("FAIL stable_on_fall: observed %b expected %b", serial_data_out, prev_sdo);
        end
        bits = {bits[22:0], serial_data_out};
        nfall++;
      end
      if (serial_data_out !== prev_sdo) begin
        tests++;
        assert ((sclk && !prev_sclk) || syncn || prev_sync) else begin
          fails++; $error("FAIL sdo_change_point: observed change with sclk=%b syncn=%b", sclk, syncn);
        end
      end
      if (prev_sync && !syncn) begin
        if (gap_valid) begin
          tests++;
          assert (gap === 4) else begin
            fails++; $error("FAIL sync_gap: observed %0d expected 4", gap);
          end
        end
        nfall = 0; bits = '0;
      end
      if (!prev_sync && syncn) begin
        tests++;
        assert (nfall === 24) else begin
          fails++; $error("FAIL fall_count: observed %0d expected 24", nfall);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $error("FAIL frame_unexpected: observed %h expected none", bits);
        end else begin
          automatic logic [23:0] e = exp_q.pop_front();
          assert (bits === e) else begin
            fails++; $error("FAIL frame_bits: observed %h expected %h", bits, e);
          end
        end
        frames++; gap = 1; gap_valid = 1;
      end else if (syncn && prev_sync) gap++;
      prev_sclk = sclk; prev_sdo = serial_data_out; prev_sync = syncn;
    end
  end
  task automatic wait_frames(input int n);
    int c = 0;
    while (frames < n && c < 500) begin @(negedge clk); c++; end
    tests++;
    assert (frames >= n) else begin
      fails++; $error("FAIL frame_timeout: observed %0d frames expected %0d", frames, n);
    end
  endtask
  task automatic check_startup();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      tests++;
      assert ({syncn, sclk, serial_data_out} === 3'b100) else begin
        fails++; $error("FAIL startup_gap%0d: observed %b expected 100", i, {syncn, sclk, serial_data_out});
      end
    end
    @(posedge clk); #1;
    tests++;
    assert ({syncn, sclk, serial_data_out} === 3'b010) else begin
      fails++; $error("FAIL startup_edge4: observed %b expected 010", {syncn, sclk, serial_data_out});
    end
  endtask
  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    assert ({syncn, sclk, serial_data_out} === 3'b100) else begin
      fails++; $error("FAIL reset_state: observed %b expected 100", {syncn, sclk, serial_data_out});
    end
    exp_q.push_back(frame_of(16'hAAAA));
    exp_q.push_back(frame_of(16'hAAAA));
    @(negedge clk);
    aresetn = 1'b1;
    check_startup();
    wait_frames(1);
    repeat (20) @(negedge clk);
    data_in = 16'h1234;
    exp_q.push_back(frame_of(16'h1234));
    wait_frames(3);
    c = 0;
    while (!(nfall == 13 && !syncn) && c < 200) begin @(negedge clk); #1; c++; end
    tests++;
    assert (nfall == 13 && !syncn) else begin
      fails++; $error("FAIL reach_bit10: observed nfall %0d expected 13", nfall);
    end
    @(posedge clk); #2;
    aresetn = 1'b0;
    #1;
    tests++;
    assert ({syncn, sclk, serial_data_out} === 3'b100) else begin
      fails++; $error("FAIL async_reset: observed %b expected 100", {syncn, sclk, serial_data_out});
    end
    repeat (2) @(negedge clk);
    data_in = 16'h8001;
    exp_q.push_back(frame_of(16'h8001));
    aresetn = 1'b1;
    check_startup();
    wait_frames(4);
    @(negedge clk);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++; $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dac8411_write.md
Name: dac8411_write

Overview:
Serial write controller for a TI DAC8411 16-bit DAC. Continuously streams the parallel word on data_in to the DAC over its 3-wire interface (SYNC, SCLK, DIN) as repeated 24-bit frames. Lives in the external-PLL design, between the ADC-count amplification logic and the board DAC pins. SCLK is derived from the system clock by dividing by 2.

Parameters:
DAC_WIDTH, 16, width of data_in; legal range 1..16; narrower words are left-justified into the 16-bit data field and zero-filled below.
PD_MODE, 2'b00, power-down bits PD1:PD0 sent at the head of every frame (00 = normal operation).
SYNC_HIGH_CYCLES, 4, clk cycles syncn is held high between frames; minimum 2.

Ports:
clk  input  1  system clock; all logic on its rising edge.
aresetn  input  1  asynchronous active-low reset.
data_in  input  DAC_WIDTH  DAC code; sampled once per frame.
sclk  output  1  serial clock to the DAC, clk/2 during a frame, low otherwise.
serial_data_out  output  1  DAC DIN, MSB first.
syncn  output  1  DAC SYNC, active low, frames each 24-bit transfer.

Behaviour:
- Clock and reset: one clock (clk); reset aresetn is asynchronous and active-low.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Reset (asserted, including mid-frame): immediately syncn=1, sclk=0, serial_data_out=0. The frame in progress is abandoned; no partial-frame recovery.
- Frame word (24 bits, sent MSB first) = {PD_MODE[1:0], data16[15:0], 6'b000000}. data16 = data_in << (16-DAC_WIDTH).
- FSM states: GAP, SHIFT.
- GAP:
  - syncn=1, sclk=0, serial_data_out=0.
  - A counter counts SYNC_HIGH_CYCLES rising edges.
  - On the edge that ends GAP, the block does all of the following on that same edge: latch the frame word from data_in into a 24-bit shift register; drive syncn=0; drive sclk=1; drive serial_data_out=bit23. It then enters SHIFT.
- After reset release, the FSM starts in GAP with the counter cleared. The first syncn falling edge therefore occurs on the SYNC_HIGH_CYCLES-th rising clk edge after aresetn deasserts.
- SHIFT (relative to frame-start edge t0):
  - sclk toggles every clk edge: high at even t, low at odd t.
  - Bit b (b=23..0) is driven from edge t=2*(23-b) and held for 2 clk cycles. Data therefore changes only on sclk rising edges and is stable across each sclk falling edge, where the DAC samples.
  - The last sclk falling edge (bit0) is at t=47.
  - At t=48: syncn=1, sclk=0, serial_data_out=0; enter GAP.
- Frame period = 48 + SYNC_HIGH_CYCLES clk cycles (52 by default); the block repeats frames indefinitely.
- data_in changes during SHIFT or GAP have no effect until the next frame-start edge, so each frame carries exactly one coherent code.
- A bit counter (0..23) and a phase bit are used. After exactly 24 sclk falling edges per frame syncn rises; never more, never fewer.
- No handshake or busy/ready signal. The DAC updates its output after the 24th falling edge, which is DAC-internal.

Test Plan:
- Reset with clk running and data_in=0xAAAA, release aresetn on a clk negedge -> syncn,sclk,serial_data_out stay 1,0,0 until syncn falls on the 4th rising edge after release.
- First frame with data_in=0xAAAA -> 24 sclk pulses. Bits sampled on sclk falling edges = 00 1010101010101010 000000. syncn rises one clk after the 24th falling edge.
- Back-to-back frames -> syncn high exactly 4 clk cycles between frames; frame-start to frame-start = 52 cycles; identical bit pattern repeats.
- Change data_in from 0xAAAA to 0x1234 mid-frame -> current frame finishes with 0xAAAA; next frame carries 0x1234 (00 0001001000110100 000000).
- Assert aresetn during bit 10 of a frame -> outputs go 1/0/0 asynchronously, before the next clk edge. After release, a fresh full frame starts 4 edges later.
- Data stability check over all frames -> serial_data_out never changes on an sclk falling edge; it only changes while sclk rises or while syncn is high.
